// File: rtl/byte_serial_add_seq_if.sv
// Bundle of the operand handshake, result handshake and external 8-bit adder
// port signals for the byte-serial add sequencer.
interface byte_serial_add_seq_if #(parameter int NBYTES = 4);
   localparam int W = 8 * NBYTES;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         op_cin;

   logic [7:0]   add_a;
   logic [7:0]   add_b;
   logic         add_cin;
   logic [7:0]   add_s;
   logic         add_cout;

   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         cout;
   logic         ovf;

   modport master (
      output in_valid, op_a, op_b, op_cin, add_s, add_cout, out_ready,
      input  in_ready, add_a, add_b, add_cin, out_valid, result, cout, ovf
   );

   modport slave (
      input  in_valid, op_a, op_b, op_cin, add_s, add_cout, out_ready,
      output in_ready, add_a, add_b, add_cin, out_valid, result, cout, ovf
   );
endinterface

// File: rtl/byte_serial_add_seq.sv
// Slices wide operands into bytes, LSB first, feeds them through an external
// 8-bit adder one per cycle, chains the carry and holds the assembled sum.
module byte_serial_add_seq #(
   parameter int NBYTES = 4
) (
   input logic                 clk,
   input logic                 rst,
   byte_serial_add_seq_if.slave bus
);
   localparam int W    = 8 * NBYTES;
   localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IDXW-1:0] LAST = IDXW'(NBYTES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state;
   state_t          state_next;
   logic [W-1:0]    a_reg;
   logic [W-1:0]    b_reg;
   logic [W-1:0]    result_reg;
   logic            carry_reg;
   logic [IDXW-1:0] idx;

   logic            in_ready;
   logic            out_valid;
   logic [7:0]      add_a;
   logic [7:0]      add_b;
   logic            add_cin;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      add_a      = 8'h00;
      add_b      = 8'h00;
      add_cin    = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) state_next = RUN;
         end
         RUN: begin
            add_a   = a_reg[8*idx +: 8];
            add_b   = b_reg[8*idx +: 8];
            add_cin = carry_reg;
            if (idx == LAST) state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (bus.out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // carry_reg doubles as the chained carry during RUN and the final cout afterwards
   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg      <= '0;
         b_reg      <= '0;
         result_reg <= '0;
         carry_reg  <= 1'b0;
         idx        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_reg      <= bus.op_a;
                  b_reg      <= bus.op_b;
                  carry_reg  <= bus.op_cin;
                  result_reg <= '0;
                  idx        <= '0;
               end
            end
            RUN: begin
               result_reg[8*idx +: 8] <= bus.add_s;
               carry_reg              <= bus.add_cout;
               idx                    <= (idx == LAST) ? '0 : idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.add_a     = add_a;
   assign bus.add_b     = add_b;
   assign bus.add_cin   = add_cin;
   assign bus.result    = result_reg;
   assign bus.cout      = carry_reg;
   assign bus.ovf       = (a_reg[W-1] == b_reg[W-1]) && (result_reg[W-1] != a_reg[W-1]);
endmodule

// File: tb/tb_byte_serial_add_seq.sv
// Directed bench for byte_serial_add_seq with NBYTES=4 and a behavioural
// 8-bit adder wired onto the add_* bus.
module tb_byte_serial_add_seq;
   logic clk;
   logic rst;
   int   checks;
   int   failures;

   byte_serial_add_seq_if #(.NBYTES(4)) bus ();

   byte_serial_add_seq #(.NBYTES(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {8'h00, bus.add_cin};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Accept one operand set and walk the RUN phase, confirming out_valid rises exactly 4 edges later
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic cin, input bit checkCin);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.op_a     = a;
      bus.op_b     = b;
      bus.op_cin   = cin;
      checkOutput("accept_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         bus.op_a     = 32'hDEADBEEF;
         bus.op_b     = 32'hCAFEF00D;
         bus.op_cin   = ~cin;
         checkOutput("busy_out_valid", 64'(bus.out_valid), 64'd0);
         checkOutput("busy_in_ready", 64'(bus.in_ready), 64'd0);
         if (checkCin) checkOutput("run_add_cin", 64'(bus.add_cin), 64'd1);
         @(posedge clk);
      end
      @(negedge clk);
      checkOutput("latency_out_valid", 64'(bus.out_valid), 64'd1);
   endtask

   task automatic checkResult(input string tag, input logic [31:0] res, input logic c, input logic o);
      checkOutput({tag, "_result"}, 64'(bus.result), 64'(res));
      checkOutput({tag, "_cout"}, 64'(bus.cout), 64'(c));
      checkOutput({tag, "_ovf"}, 64'(bus.ovf), 64'(o));
   endtask

   task automatic handoff();
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      checkOutput("handoff_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("handoff_in_ready", 64'(bus.in_ready), 64'd1);
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.op_a      = '0;
      bus.op_b      = '0;
      bus.op_cin    = 1'b0;
      bus.out_ready = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
      checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
      checkResult("rst", 32'h0, 1'b0, 1'b0);
      checkOutput("rst_add_a", 64'(bus.add_a), 64'd0);
      checkOutput("rst_add_b", 64'(bus.add_b), 64'd0);
      checkOutput("rst_add_cin", 64'(bus.add_cin), 64'd0);
      rst = 1'b0;

      applyStimulus(32'h000000FF, 32'h00000001, 1'b0, 1'b0);
      checkResult("carry_chain", 32'h00000100, 1'b0, 1'b0);
      handoff();

      applyStimulus(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1);
      checkResult("full_wrap", 32'h00000000, 1'b1, 1'b0);
      handoff();

      applyStimulus(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
      checkResult("ovf_pos", 32'h80000000, 1'b0, 1'b1);
      handoff();

      applyStimulus(32'h80000000, 32'h80000000, 1'b0, 1'b0);
      checkResult("ovf_neg", 32'h00000000, 1'b1, 1'b1);
      handoff();

      // Backpressure: DONE holds while a new operand set waits on in_valid
      applyStimulus(32'h12345678, 32'h11111111, 1'b0, 1'b0);
      bus.in_valid = 1'b1;
      bus.op_a     = 32'hAAAAAAAA;
      bus.op_b     = 32'h55555555;
      bus.op_cin   = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         checkResult("stall", 32'h23456789, 1'b0, 1'b0);
         checkOutput("stall_in_ready", 64'(bus.in_ready), 64'd0);
         checkOutput("stall_out_valid", 64'(bus.out_valid), 64'd1);
      end
      handoff();
      @(posedge clk);
      for (int i = 0; i < 4; i++) @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      checkOutput("bp_out_valid", 64'(bus.out_valid), 64'd1);
      checkResult("bp_next", 32'hFFFFFFFF, 1'b0, 1'b0);
      handoff();

      // Reset during the second RUN cycle discards the operation
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.op_a     = 32'h01020304;
      bus.op_b     = 32'h10203040;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checkOutput("abort_in_ready", 64'(bus.in_ready), 64'd1);
      checkOutput("abort_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("abort_result", 64'(bus.result), 64'd0);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput("abort_no_valid", 64'(bus.out_valid), 64'd0);
      end

      applyStimulus(32'h00000001, 32'h00000001, 1'b0, 1'b0);
      checkResult("post_abort", 32'h00000002, 1'b0, 1'b0);
      handoff();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/byte_serial_add_seq.md
# byte_serial_add_seq

Sequencing stage that sits directly upstream of the team's 8-bit ripple-carry adder (ports A, B, Cin → S, Cout). It accepts wide operands through a valid/ready handshake and slices them into bytes, least-significant first. It drives one byte pair per cycle into the external 8-bit adder and chains the carry across cycles. It assembles the wide sum, carry-out and signed-overflow flag, and holds them until the consumer takes them.

## Interface
- NBYTES, default 4: operand width in bytes; W = 8*NBYTES; legal range 1–8.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set present.
- in_ready  output  1  block can accept; high only in IDLE.
- op_a  input  W  operand A.
- op_b  input  W  operand B.
- op_cin  input  1  carry into byte 0.
- add_a  output  8  byte of A to adder port A.
- add_b  output  8  byte of B to adder port B.
- add_cin  output  1  carry to adder port Cin.
- add_s  input  8  adder sum S (combinational from add_a/add_b/add_cin).
- add_cout  input  1  adder Cout.
- out_valid  output  1  result held and valid.
- out_ready  input  1  consumer takes result.
- result  output  W  assembled sum.
- cout  output  1  carry out of MSB byte.
- ovf  output  1  signed overflow: op_a[W-1]==op_b[W-1] and result[W-1]!=op_a[W-1].

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready at an edge, latch op_a, op_b and op_cin into a_reg, b_reg and carry_reg. Clear idx to 0 and result_reg to 0. Go to RUN.
- RUN: add_a=a_reg[8*idx+:8], add_b=b_reg[8*idx+:8], add_cin=carry_reg.
  - Each edge: result_reg[8*idx+:8]<=add_s, carry_reg<=add_cout, idx<=idx+1.
  - When idx==NBYTES-1 at an edge, go to DONE.
- DONE: out_valid=1. result, cout and ovf are stable.
  - On out_valid&out_ready at an edge, go to IDLE.
  - Outputs keep their last values until the next acceptance clears result_reg.
- add_a, add_b and add_cin are 0 outside RUN.
- ovf is computed from the latched a_reg/b_reg sign bits and result_reg[W-1]. It is meaningful only while out_valid=1.
- idx width is clog2(NBYTES), minimum 1. idx never exceeds NBYTES-1.
- No arithmetic is performed internally. The block relies entirely on the external adder.
- Inputs op_a, op_b and op_cin are ignored outside the accept edge. Changing them during RUN has no effect.

## Timing
- Reset values, applied at the first rising edge with rst=1:
  - state=IDLE, in_ready=1, out_valid=0.
  - result=0, cout=0, ovf=0.
  - add_a=0, add_b=0, add_cin=0, idx=0.
- rst takes priority over every other condition in every state.
- Reset mid-RUN or mid-DONE aborts the operation. A pending result is discarded, not delivered.
- Latency: operands accepted at edge k. Bytes are captured at edges k+1 … k+NBYTES. out_valid goes high after edge k+NBYTES.
- Throughput: one operation per NBYTES+2 cycles minimum (accept, NBYTES RUN cycles, DONE with out_ready already high).
- in_ready is 0 in RUN and DONE. A new accept cannot happen in the same cycle as the result handoff; the earliest re-accept is the edge after the handoff.
- out_ready low in DONE stalls indefinitely with all outputs held. out_ready high outside DONE is ignored.
- in_valid high in RUN or DONE is not an accept. The upstream source must hold in_valid and its operands until in_ready=1.
- The external adder path is combinational within one cycle. The clock period must cover the 8-bit ripple delay plus the mux and register setup.
- NBYTES=1: a single RUN cycle, otherwise identical.

## Test plan
- Bench setup: NBYTES=4, with the team's 8-bit adder connected to add_*.
- Reset check: assert rst for 2 cycles → in_ready=1, out_valid=0, result=0, cout=0, ovf=0, add_a=add_b=0.
- Carry chain: op_a=0x000000FF, op_b=0x00000001, op_cin=0 → after 4 RUN cycles result=0x00000100, cout=0, ovf=0. Also check out_valid rises exactly 4 edges after the accept.
- Full wrap: op_a=0xFFFFFFFF, op_b=0x00000000, op_cin=1 → result=0x00000000, cout=1, ovf=0. Check add_cin=1 in every RUN cycle.
- Signed overflow: op_a=0x7FFFFFFF, op_b=0x00000001, op_cin=0 → result=0x80000000, cout=0, ovf=1. Also op_a=0x80000000, op_b=0x80000000 → result=0, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → result, cout and ovf are unchanged and in_ready=0. With in_valid=1 throughout, no new operands are taken. Raise out_ready → IDLE next edge, then accept the next operands 0xAAAAAAAA+0x55555555 → result=0xFFFFFFFF, cout=0.
- Reset mid-operation: assert rst in the 2nd RUN cycle → state IDLE next edge, out_valid never rises. A subsequent 1+1 (op_cin=0) completes normally with result=0x00000002.
